// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU sequencer: FSM state encoding and the
// instruction field layout (MSB first: comm, mode, cin, b_sel, rd, rs1, rs2, imm).
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam int unsigned COMM_WIDTH = 4;
    // comm + mode + cin + b_sel
    localparam int unsigned CTRL_WIDTH = COMM_WIDTH + 3;

    function automatic int unsigned instr_width(input int unsigned dw, input int unsigned aw);
        return dw + 3 * aw + CTRL_WIDTH;
    endfunction

    function automatic int unsigned imm_lsb();
        return 0;
    endfunction

    function automatic int unsigned rs2_lsb(input int unsigned dw);
        return dw;
    endfunction

    function automatic int unsigned rs1_lsb(input int unsigned dw, input int unsigned aw);
        return dw + aw;
    endfunction

    function automatic int unsigned rd_lsb(input int unsigned dw, input int unsigned aw);
        return dw + 2 * aw;
    endfunction

    function automatic int unsigned bsel_pos(input int unsigned dw, input int unsigned aw);
        return dw + 3 * aw;
    endfunction

    function automatic int unsigned cin_pos(input int unsigned dw, input int unsigned aw);
        return dw + 3 * aw + 1;
    endfunction

    function automatic int unsigned mode_pos(input int unsigned dw, input int unsigned aw);
        return dw + 3 * aw + 2;
    endfunction

    function automatic int unsigned comm_lsb(input int unsigned dw, input int unsigned aw);
        return dw + 3 * aw + 3;
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational instruction field splitter.
// Ports: instr (packed instruction) in; comm/mode/cin/b_sel/rd/rs1/rs2/imm fields out.
module cpu_seq_decode
    import cpu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3,
    localparam int unsigned INSTR_WIDTH = DATA_WIDTH + 3 * ADDR_WIDTH + CTRL_WIDTH
) (
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [COMM_WIDTH-1:0]  comm_c,
    output logic                   mode_c,
    output logic                   cin_c,
    output logic                   b_sel_c,
    output logic [ADDR_WIDTH-1:0]  rd_c,
    output logic [ADDR_WIDTH-1:0]  rs1_c,
    output logic [ADDR_WIDTH-1:0]  rs2_c,
    output logic [DATA_WIDTH-1:0]  imm_c
);

    localparam int unsigned IMM_LSB  = imm_lsb();
    localparam int unsigned RS2_LSB  = rs2_lsb(DATA_WIDTH);
    localparam int unsigned RS1_LSB  = rs1_lsb(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned RD_LSB   = rd_lsb(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned BSEL_POS = bsel_pos(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned CIN_POS  = cin_pos(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned MODE_POS = mode_pos(DATA_WIDTH, ADDR_WIDTH);
    localparam int unsigned COMM_LSB = comm_lsb(DATA_WIDTH, ADDR_WIDTH);

    assign imm_c   = instr[IMM_LSB +: DATA_WIDTH];
    assign rs2_c   = instr[RS2_LSB +: ADDR_WIDTH];
    assign rs1_c   = instr[RS1_LSB +: ADDR_WIDTH];
    assign rd_c    = instr[RD_LSB +: ADDR_WIDTH];
    assign b_sel_c = instr[BSEL_POS];
    assign cin_c   = instr[CIN_POS];
    assign mode_c  = instr[MODE_POS];
    assign comm_c  = instr[COMM_LSB +: COMM_WIDTH];

endmodule

// File: rtl/cpu_sequencer.sv
// Three-state instruction sequencer sitting next to cpu_top: accepts host
// register writes and instructions, drives the ALU from a latched instruction,
// captures the ALU result and writes it back one cycle later.
// Ports: clk/reset; host write handshake (host_wr_*); instruction handshake
// (instr_valid/instr_ready/instr); register file write/read controls (reg_*);
// ALU controls (alu_comm/mode/cin, b_source_sel, alu_b_imm) and ALU returns
// (alu_result/alu_cout); retire status (done, result, carry_flag, retired_count).
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 8,
    localparam int unsigned ADDR_WIDTH  = $clog2(NUM_REGS),
    localparam int unsigned INSTR_WIDTH = DATA_WIDTH + 3 * ADDR_WIDTH + CTRL_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_wr_valid,
    output logic                   host_wr_ready,
    input  logic [ADDR_WIDTH-1:0]  host_wr_addr,
    input  logic [DATA_WIDTH-1:0]  host_wr_data,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   reg_write_enable,
    output logic [ADDR_WIDTH-1:0]  reg_write_addr,
    output logic [DATA_WIDTH-1:0]  reg_write_data,
    output logic [ADDR_WIDTH-1:0]  reg_read_addr1,
    output logic [ADDR_WIDTH-1:0]  reg_read_addr2,
    output logic [3:0]             alu_comm,
    output logic                   alu_mode,
    output logic                   alu_cin,
    output logic                   b_source_sel,
    output logic [DATA_WIDTH-1:0]  alu_b_imm,
    input  logic [DATA_WIDTH-1:0]  alu_result,
    input  logic                   alu_cout,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   carry_flag,
    output logic [15:0]            retired_count
);

    state_t state;
    state_t state_nxt;

    logic [INSTR_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0]  alu_res_q;
    logic                   alu_cout_q;
    logic                   instr_fire_c;

    logic [COMM_WIDTH-1:0] dec_comm;
    logic                  dec_mode;
    logic                  dec_cin;
    logic                  dec_b_sel;
    logic [ADDR_WIDTH-1:0] dec_rd;
    logic [ADDR_WIDTH-1:0] dec_rs1;
    logic [ADDR_WIDTH-1:0] dec_rs2;
    logic [DATA_WIDTH-1:0] dec_imm;

    // Field split of the latched instruction
    cpu_seq_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .instr   (instr_q),
        .comm_c  (dec_comm),
        .mode_c  (dec_mode),
        .cin_c   (dec_cin),
        .b_sel_c (dec_b_sel),
        .rd_c    (dec_rd),
        .rs1_c   (dec_rs1),
        .rs2_c   (dec_rs2),
        .imm_c   (dec_imm)
    );

    // ALU controls follow the latch, so they hold the last instruction outside EXEC
    assign alu_comm       = dec_comm;
    assign alu_mode       = dec_mode;
    assign alu_cin        = dec_cin;
    assign b_source_sel   = dec_b_sel;
    assign alu_b_imm      = dec_imm;
    assign reg_read_addr1 = dec_rs1;
    assign reg_read_addr2 = dec_rs2;

    assign instr_fire_c = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_fire_c) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; host writes bypass straight to the register file in IDLE
    always_comb begin
        host_wr_ready    = 1'b0;
        instr_ready      = 1'b0;
        reg_write_enable = 1'b0;
        reg_write_addr   = '0;
        reg_write_data   = '0;
        done             = 1'b0;
        case (state)
            IDLE: begin
                host_wr_ready = 1'b1;
                instr_ready   = !host_wr_valid;
                if (host_wr_valid) begin
                    reg_write_enable = 1'b1;
                    reg_write_addr   = host_wr_addr;
                    reg_write_data   = host_wr_data;
                end
            end
            WB: begin
                reg_write_enable = 1'b1;
                reg_write_addr   = dec_rd;
                reg_write_data   = alu_res_q;
                done             = 1'b1;
            end
            default: ;
        endcase
        // Reset aborts any in-flight write or retire
        if (reset) begin
            host_wr_ready    = 1'b0;
            instr_ready      = 1'b0;
            reg_write_enable = 1'b0;
            done             = 1'b0;
        end
    end

    // Instruction latch, ALU capture and retire bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q       <= '0;
            alu_res_q     <= '0;
            alu_cout_q    <= 1'b0;
            result        <= '0;
            carry_flag    <= 1'b0;
            retired_count <= '0;
        end else begin
            if (state == IDLE && instr_fire_c) begin
                instr_q <= instr;
            end
            if (state == EXEC) begin
                alu_res_q  <= alu_result;
                alu_cout_q <= alu_cout;
            end
            if (state == WB) begin
                result        <= alu_res_q;
                carry_flag    <= alu_cout_q;
                retired_count <= retired_count + 16'd1;
            end
        end
    end

endmodule
